hbridge_driver: RTL and testbench

HBRIDGE_DRIVER -- requirements
Module: hbridge_driver

---
 rtl/hbridge_driver.sv | 187 ++++++++++++++++++
 tb/tb_hbridge_driver.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hbridge_driver.sv
// Dual-channel H-bridge driver.
// Each channel runs its own STOP/FWD/REV/DEAD state machine. Both bridge legs are held
// off for DEAD_CYCLES clocks on every run-to-stop or reversal transition. A shared 12-bit
// PWM counter gates the enable pins against a per-channel duty that only changes at
// period boundaries.
// Optional feature: define HBRIDGE_SOFT_START_EN to ramp the duty up by RAMP_STEP per
// PWM period after each entry into FWD or REV.
module hbridge_driver #(
    parameter int unsigned DEAD_CYCLES = 1000,
    parameter int unsigned RAMP_STEP   = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  directie_driverA,
    input  logic [1:0]  directie_driverB,
    input  logic [11:0] factor_dc_driverA,
    input  logic [11:0] factor_dc_driverB,
    output logic        in1_a,
    output logic        in2_a,
    output logic        in1_b,
    output logic        in2_b,
    output logic        en_a,
    output logic        en_b,
    output logic        busy_a,
    output logic        busy_b
);

    localparam logic [1:0] StStop = 2'd0;
    localparam logic [1:0] StFwd  = 2'd1;
    localparam logic [1:0] StRev  = 2'd2;
    localparam logic [1:0] StDead = 2'd3;

    // Counter only needs to hold DEAD_CYCLES-1.
    localparam int unsigned   CntW     = (DEAD_CYCLES > 2) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [CntW-1:0] DeadLoad = CntW'(DEAD_CYCLES - 1);

    // Index 0 is channel A, index 1 is channel B.
    logic [1:0][1:0]      cmd;
    logic [1:0][11:0]     target;
    logic [1:0][1:0]      state_q, state_d;
    logic [1:0][CntW-1:0] dead_q, dead_d;
    logic [1:0][11:0]     duty_q, duty_d;
    logic [1:0]           run_q, run_d;
    logic [1:0]           in1_q, in2_q, en_q, busy_q;
    logic [11:0]          pwm_q, pwm_d;
    logic                 boundary;

    assign cmd    = {directie_driverB, directie_driverA};
    assign target = {factor_dc_driverB, factor_dc_driverA};

    assign pwm_d    = pwm_q + 12'd1;
    assign boundary = (pwm_q == 12'hFFF);

    // Command decode used when leaving STOP or DEAD.
    function automatic logic [1:0] decode_cmd(input logic [1:0] c);
        case (c)
            2'b10:   decode_cmd = StFwd;
            2'b01:   decode_cmd = StRev;
            default: decode_cmd = StStop;
        endcase
    endfunction

    // Per-channel state transitions and dead-time counter.
    always_comb begin
        state_d = state_q;
        dead_d  = dead_q;
        for (int ch = 0; ch < 2; ch++) begin
            case (state_q[ch])
                StStop: state_d[ch] = decode_cmd(cmd[ch]);
                StFwd: begin
                    if (cmd[ch] != 2'b10) begin
                        state_d[ch] = StDead;
                        dead_d[ch]  = DeadLoad;
                    end
                end
                StRev: begin
                    if (cmd[ch] != 2'b01) begin
                        state_d[ch] = StDead;
                        dead_d[ch]  = DeadLoad;
                    end
                end
                StDead: begin
                    // Only the command present on the final DEAD clock matters.
                    if (dead_q[ch] == '0) begin
                        state_d[ch] = decode_cmd(cmd[ch]);
                    end else begin
                        dead_d[ch] = dead_q[ch] - CntW'(1);
                    end
                end
                default: state_d[ch] = StStop;
            endcase
        end
    end

    // Running flags for the current and next state.
    always_comb begin
        run_q = '0;
        run_d = '0;
        for (int ch = 0; ch < 2; ch++) begin
            run_q[ch] = (state_q[ch] == StFwd) || (state_q[ch] == StRev);
            run_d[ch] = (state_d[ch] == StFwd) || (state_d[ch] == StRev);
        end
    end

`ifdef HBRIDGE_SOFT_START_EN
    localparam logic [12:0] RampStep = (RAMP_STEP > 32'd4095) ? 13'd4095 : 13'(RAMP_STEP);

    logic [1:0][12:0] ramp_sum;
    logic [1:0][11:0] ramp_sat;

    // Soft start: restart at 0 on run entry, then step up toward the target each period.
    always_comb begin
        ramp_sum = '0;
        ramp_sat = '0;
        duty_d   = duty_q;
        for (int ch = 0; ch < 2; ch++) begin
            ramp_sum[ch] = {1'b0, duty_q[ch]} + RampStep;
            ramp_sat[ch] = ramp_sum[ch][12] ? 12'hFFF : ramp_sum[ch][11:0];
            if (run_d[ch] && !run_q[ch]) begin
                duty_d[ch] = 12'd0;
            end else if (boundary) begin
                // min() also applies a lowered target at the next boundary.
                duty_d[ch] = (ramp_sat[ch] < target[ch]) ? ramp_sat[ch] : target[ch];
            end
        end
    end
`else
    // Duty target is picked up only at the period boundary.
    always_comb begin
        duty_d = duty_q;
        for (int ch = 0; ch < 2; ch++) begin
            if (boundary) begin
                duty_d[ch] = target[ch];
            end
        end
    end
`endif

    // Shared free-running PWM counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_q <= 12'd0;
        end else begin
            pwm_q <= pwm_d;
        end
    end

    // Channel state, dead counter and effective duty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= {StStop, StStop};
            dead_q  <= '0;
            duty_q  <= '0;
        end else begin
            state_q <= state_d;
            dead_q  <= dead_d;
            duty_q  <= duty_d;
        end
    end

    // Registered outputs, decoded from the next state so legs follow the command in one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in1_q  <= '0;
            in2_q  <= '0;
            en_q   <= '0;
            busy_q <= '0;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                in1_q[ch]  <= (state_d[ch] == StFwd);
                in2_q[ch]  <= (state_d[ch] == StRev);
                en_q[ch]   <= run_d[ch] && (pwm_d < duty_d[ch]);
                busy_q[ch] <= (state_d[ch] == StDead);
            end
        end
    end

    assign in1_a  = in1_q[0];
    assign in2_a  = in2_q[0];
    assign en_a   = en_q[0];
    assign busy_a = busy_q[0];
    assign in1_b  = in1_q[1];
    assign in2_b  = in2_q[1];
    assign en_b   = en_q[1];
    assign busy_b = busy_q[1];

endmodule

// File: tb/tb_hbridge_driver.sv
// Testbench for hbridge_driver with DEAD_CYCLES=8, RAMP_STEP=1024.
// Directed scenarios plus randomized commands, checked every cycle against a
// behavioural model of the channel rules.
module tb_hbridge_driver;

    localparam int DeadCycles = 8;
    localparam int RampStep   = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  dir_a = 2'b00;
    logic [1:0]  dir_b = 2'b00;
    logic [11:0] duty_a = 12'd0;
    logic [11:0] duty_b = 12'd0;
    logic        in1_a, in2_a, in1_b, in2_b, en_a, en_b, busy_a, busy_b;
    logic [7:0]  dut_vec;

    always #5 clk = ~clk;

    hbridge_driver #(
        .DEAD_CYCLES(DeadCycles),
        .RAMP_STEP  (RampStep)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .directie_driverA (dir_a),
        .directie_driverB (dir_b),
        .factor_dc_driverA(duty_a),
        .factor_dc_driverB(duty_b),
        .in1_a            (in1_a),
        .in2_a            (in2_a),
        .in1_b            (in1_b),
        .in2_b            (in2_b),
        .en_a             (en_a),
        .en_b             (en_b),
        .busy_a           (busy_a),
        .busy_b           (busy_b)
    );

    assign dut_vec = {in1_a, in2_a, en_a, busy_a, in1_b, in2_b, en_b, busy_b};

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 stopped, 1 forward, 2 reverse, 3 dead-time
    int m_mode [2];
    int m_left [2];
    int m_duty [2];
    int m_pwm;
    int t_want, t_tgt, t_sum;
    bit t_bnd, t_was_run, t_now_run;

    function automatic int want_of(input logic [1:0] c);
        if (c == 2'b10) return 1;
        if (c == 2'b01) return 2;
        return 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int ch = 0; ch < 2; ch++) begin
                m_mode[ch] = 0;
                m_left[ch] = 0;
                m_duty[ch] = 0;
            end
            m_pwm = 0;
        end else begin
            t_bnd = (m_pwm == 4095);
            for (int ch = 0; ch < 2; ch++) begin
                t_want    = want_of(ch == 0 ? dir_a : dir_b);
                t_tgt     = (ch == 0) ? int'(duty_a) : int'(duty_b);
                t_was_run = (m_mode[ch] == 1) || (m_mode[ch] == 2);
                if (m_mode[ch] == 3) begin
                    m_left[ch] = m_left[ch] - 1;
                    if (m_left[ch] == 0) m_mode[ch] = t_want;
                end else if (m_mode[ch] == 0) begin
                    m_mode[ch] = t_want;
                end else if (t_want != m_mode[ch]) begin
                    m_mode[ch] = 3;
                    m_left[ch] = DeadCycles;
                end
                t_now_run = (m_mode[ch] == 1) || (m_mode[ch] == 2);
`ifdef HBRIDGE_SOFT_START_EN
                if (t_now_run && !t_was_run) begin
                    m_duty[ch] = 0;
                end else if (t_bnd) begin
                    t_sum = m_duty[ch] + RampStep;
                    if (t_sum > 4095) t_sum = 4095;
                    m_duty[ch] = (t_sum < t_tgt) ? t_sum : t_tgt;
                end
`else
                if (t_bnd) m_duty[ch] = t_tgt;
`endif
            end
            m_pwm = (m_pwm + 1) % 4096;
        end
    end

    function automatic logic [7:0] exp_vec();
        logic [7:0] v;
        logic [3:0] c [2];
        for (int ch = 0; ch < 2; ch++) begin
            c[ch][3] = (m_mode[ch] == 1);
            c[ch][2] = (m_mode[ch] == 2);
            c[ch][1] = ((m_mode[ch] == 1) || (m_mode[ch] == 2)) && (m_pwm < m_duty[ch]);
            c[ch][0] = (m_mode[ch] == 3);
        end
        v = {c[0], c[1]};
        return v;
    endfunction

    // ---------------- helpers ----------------
    // Advance to the next falling edge and compare all outputs against the model.
    task automatic cycle();
        @(negedge clk);
        check_val("outs", {24'd0, dut_vec}, {24'd0, exp_vec()});
    endtask

    task automatic wait_bnd();
        int g;
        g = 0;
        while (m_pwm != 0 && g < 5000) begin
            cycle();
            g++;
        end
        if (g >= 5000) check_val("bnd_timeout", 32'd1, 32'd0);
    endtask

    task automatic period_count(output int hi);
        hi = 0;
        repeat (4096) begin
            hi += int'(en_a);
            cycle();
        end
    endtask

    int n, hi, legs, busy_seen, g;
    int soft_exp [4];

    initial begin
        // Reset state
        #1 rst = 1'b1;
        cycle();
        check_val("rst_outs", {24'd0, dut_vec}, 32'd0);
        cycle();

        // Forward at 50% duty
        rst = 1'b0;
        dir_a = 2'b10;
        duty_a = 12'd2048;
        cycle();
        check_val("fwd_legs", {30'd0, in1_a, in2_a}, 32'd2);
        wait_bnd();
        period_count(hi);
`ifdef HBRIDGE_SOFT_START_EN
        check_val("duty_2048", hi, 32'd1024);
`else
        check_val("duty_2048", hi, 32'd2048);
`endif

        // Reversal: exactly 8 dead clocks with both legs off
        dir_a = 2'b01;
        cycle();
        n = 0;
        legs = 0;
        while (busy_a && n < 20) begin
            n++;
            legs |= int'(in1_a | in2_a | en_a);
            cycle();
        end
        check_val("dead_len", n, 32'd8);
        check_val("dead_legs", legs, 32'd0);
        check_val("rev_legs", {30'd0, in1_a, in2_a}, 32'd1);

        // Command toggling inside DEAD; only the last DEAD clock counts
        dir_a = 2'b10;
        cycle();
        busy_seen = 0;
        legs = 0;
        for (int k = 1; k <= 8; k++) begin
            busy_seen += int'(busy_a);
            legs |= int'(in1_a | in2_a | en_a);
            dir_a = (k <= 2) ? 2'b01 : ((k <= 4) ? 2'b10 : 2'b00);
            cycle();
        end
        check_val("dead_len2", busy_seen, 32'd8);
        check_val("dead_legs2", legs, 32'd0);
        check_val("dead_exit_stop", {29'd0, in1_a, in2_a, busy_a}, 32'd0);

        // Duty change mid-period takes effect at the next period
        dir_a = 2'b10;
        duty_a = 12'd1000;
        cycle();
        wait_bnd();
        hi = 0;
        for (int i = 0; i < 4096; i++) begin
            if (i == 2000) duty_a = 12'd3000;
            hi += int'(en_a);
            cycle();
        end
        check_val("duty_1000", hi, 32'd1000);
        period_count(hi);
`ifdef HBRIDGE_SOFT_START_EN
        check_val("duty_3000", hi, 32'd2024);
`else
        check_val("duty_3000", hi, 32'd3000);
`endif

        // Reset pulsed during the DEAD that follows REV
        dir_a = 2'b01;
        cycle();
        g = 0;
        while (busy_a && g < 20) begin
            g++;
            cycle();
        end
        check_val("rev_again", {30'd0, in1_a, in2_a}, 32'd1);
        dir_a = 2'b10;
        cycle();
        cycle();
        check_val("in_dead", {31'd0, busy_a}, 32'd1);
        #2 rst = 1'b1;
        #1 check_val("rst_async", {24'd0, dut_vec}, 32'd0);
        cycle();
        rst = 1'b0;
        cycle();
        check_val("rst_fwd", {29'd0, in1_a, in2_a, busy_a}, 32'd4);

        // Both channels change on the same clock
        dir_a = 2'b00;
        dir_b = 2'b01;
        duty_b = 12'd500;
        cycle();
        check_val("dual_change", {28'd0, in1_a, in2_a, busy_a, in2_b}, 32'd3);
        dir_b = 2'b00;
        cycle();
        check_val("dual_busy", {30'd0, busy_a, busy_b}, 32'd3);
        repeat (12) cycle();
        check_val("dual_stop", {24'd0, dut_vec}, 32'd0);

`ifdef HBRIDGE_SOFT_START_EN
        // Soft-start ramp at full duty
        duty_a = 12'd4095;
        dir_a = 2'b10;
        cycle();
        hi = 0;
        g = 0;
        while (m_pwm != 0 && g < 5000) begin
            hi += int'(en_a);
            g++;
            cycle();
        end
        check_val("ramp_0", hi, 32'd0);
        soft_exp[0] = 1024;
        soft_exp[1] = 2048;
        soft_exp[2] = 3072;
        soft_exp[3] = 4095;
        for (int p = 0; p < 4; p++) begin
            period_count(hi);
            check_val("ramp_step", hi, soft_exp[p]);
        end
        dir_a = 2'b00;
`endif

        // Randomized commands, duties and occasional resets
        for (int i = 0; i < 9000; i++) begin
            if ($urandom_range(0, 63) == 0) dir_a = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 63) == 0) dir_b = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 255) == 0) begin
                case ($urandom_range(0, 3))
                    0: duty_a = 12'd0;
                    1: duty_a = 12'd4095;
                    default: duty_a = 12'($urandom_range(0, 4095));
                endcase
            end
            if ($urandom_range(0, 255) == 0) duty_b = 12'($urandom_range(0, 4095));
            if ($urandom_range(0, 1999) == 0) begin
                rst = 1'b1;
                cycle();
                rst = 1'b0;
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
